// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Handles load-use stalls, EX redirects, data-memory back-pressure and
// halt draining, and keeps saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_useRs1,
    input  logic             ID_useRs2,
    input  logic             ID_halt,
    input  logic [4:0]       EX_rd,
    input  logic             EX_memRead,
    input  logic             EX_redirect,
    input  logic             MEM_busy,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0]       DRAIN_ONE  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;
    logic             stall_inc, flush_inc;

    // Load-use: the load in EX writes a register the ID instruction reads.
    always_comb begin
        load_use = EX_memRead && (EX_rd != 5'd0) &&
                   ((ID_useRs1 && (ID_rs1 == EX_rd)) ||
                    (ID_useRs2 && (ID_rs2 == EX_rd)));
    end

    // Next-state and pipeline control. The MEMWAIT cycle in which memory
    // becomes ready is treated as RUN, so EX_redirect held in EX during the
    // wait is acted on the moment the pipeline is released.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (state_q)
            RUN, MEMWAIT: begin
                if (MEM_busy) begin
                    state_d = MEMWAIT;
                end else begin
                    state_d = RUN;
                    if (EX_redirect) begin
                        PC_write     = 1'b1;
                        IF_ID_write  = 1'b1;
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                        ID_EX_write  = 1'b1;
                        EX_MEM_write = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        ID_EX_bubble = 1'b1;
                        ID_EX_write  = 1'b1;
                        EX_MEM_write = 1'b1;
                        stall_inc    = 1'b1;
                    end else if (ID_halt) begin
                        // Halt moves on to EX; front end freezes behind it.
                        ID_EX_write  = 1'b1;
                        EX_MEM_write = 1'b1;
                        state_d      = DRAIN;
                        drain_d      = DRAIN_INIT;
                    end else begin
                        PC_write     = 1'b1;
                        IF_ID_write  = 1'b1;
                        ID_EX_write  = 1'b1;
                        EX_MEM_write = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Feed bubbles behind the halt until the back end is empty.
                ID_EX_bubble = 1'b1;
                ID_EX_write  = !MEM_busy;
                EX_MEM_write = !MEM_busy;
                if (!MEM_busy) begin
                    if (drain_q == 4'd0) state_d = HALTED;
                    else                 drain_d = drain_q - DRAIN_ONE;
                end
            end
            default: ;  // HALTED: everything frozen until reset
        endcase
    end

    // Saturating performance counter updates.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
        if (flush_inc && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_ONE;
    end

    // State, drain counter and performance counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            drain_q <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted    = (state_q == HALTED);
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall, redirect, memory wait, halt drain,
// counter saturation and reset behaviour, with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int CW = 4;

    // Control vector order: {PC_write, IF_ID_write, IF_ID_flush,
    //                        ID_EX_bubble, ID_EX_write, EX_MEM_write}
    localparam logic [5:0] C_NORM  = 6'b110011;
    localparam logic [5:0] C_HOLD  = 6'b000000;
    localparam logic [5:0] C_REDIR = 6'b111111;
    localparam logic [5:0] C_LU    = 6'b000111;
    localparam logic [5:0] C_HALT  = 6'b000011;
    localparam logic [5:0] C_DRN   = 6'b000111;
    localparam logic [5:0] C_DRNB  = 6'b000100;

    logic          CLK = 1'b0;
    logic          RST;
    logic [4:0]    ID_rs1, ID_rs2, EX_rd;
    logic          ID_useRs1, ID_useRs2, ID_halt, EX_memRead, EX_redirect, MEM_busy;
    logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write, EX_MEM_write;
    logic          halted;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [5:0]    ctl;

    int n_chk  = 0;
    int n_pass = 0;

    hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2),
        .ID_halt(ID_halt), .EX_rd(EX_rd),
        .EX_memRead(EX_memRead), .EX_redirect(EX_redirect),
        .MEM_busy(MEM_busy),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
        .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write, EX_MEM_write};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_useRs1 = 1'b0; ID_useRs2 = 1'b0;
        ID_halt = 1'b0; EX_rd = 5'd0; EX_memRead = 1'b0;
        EX_redirect = 1'b0; MEM_busy = 1'b0;
    endtask

    task automatic load_dep();
        EX_memRead = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_useRs2 = 1'b1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        #2;
        // Reset state; outputs follow RUN rules from inputs
        chk("rst_ctl",    32'(ctl), 32'(C_NORM));
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall",  32'(stall_cnt), 32'd0);
        chk("rst_flush",  32'(flush_cnt), 32'd0);
        EX_redirect = 1'b1; #1;
        chk("rst_redir_ctl", 32'(ctl), 32'(C_REDIR));
        EX_redirect = 1'b0;
        cyc();
        RST = 1'b0;
        cyc();

        // Load followed by dependent instruction: one stall
        load_dep(); #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        cyc();
        chk("lu_stall", 32'(stall_cnt), 32'd1);
        idle();

        // No stall when EX_rd is x0 or the source is unused
        load_dep(); EX_rd = 5'd0; ID_rs2 = 5'd0; #1;
        chk("lu_x0_ctl", 32'(ctl), 32'(C_NORM));
        load_dep(); ID_useRs2 = 1'b0; #1;
        chk("lu_nouse_ctl", 32'(ctl), 32'(C_NORM));
        ID_useRs1 = 1'b1; ID_rs1 = 5'd5; #1;
        chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        ID_useRs1 = 1'b0;
        cyc();
        chk("lu_nouse_stall", 32'(stall_cnt), 32'd1);

        // Redirect wins over load-use
        load_dep(); EX_redirect = 1'b1; #1;
        chk("redir_ctl", 32'(ctl), 32'(C_REDIR));
        cyc();
        chk("redir_flush", 32'(flush_cnt), 32'd1);
        chk("redir_stall", 32'(stall_cnt), 32'd1);
        idle();

        // Memory busy for 3 cycles, then normal flow on the 4th
        MEM_busy = 1'b1; EX_redirect = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("memw_ctl%0d", i), 32'(ctl), 32'(C_HOLD));
            cyc();
        end
        MEM_busy = 1'b0; #1;
        chk("memw_rel_ctl", 32'(ctl), 32'(C_NORM));
        cyc();

        // Redirect held during a wait is acted on at release
        MEM_busy = 1'b1; EX_redirect = 1'b1; #1;
        chk("memw_redir_hold", 32'(ctl), 32'(C_HOLD));
        cyc();
        chk("memw_redir_noflush", 32'(flush_cnt), 32'd1);
        MEM_busy = 1'b0; #1;
        chk("memw_redir_rel", 32'(ctl), 32'(C_REDIR));
        cyc();
        chk("memw_redir_flush", 32'(flush_cnt), 32'd2);
        idle();

        // Stall counter saturates at 15
        load_dep();
        for (int i = 0; i < 16; i++) cyc();
        chk("sat_stall", 32'(stall_cnt), 32'd15);
        cyc();
        chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
        idle();

        // Halt: drain 4 cycles plus one busy cycle -> halted 6 cycles later
        ID_halt = 1'b1; #1;
        chk("halt_ctl", 32'(ctl), 32'(C_HALT));
        cyc();
        ID_halt = 1'b0; MEM_busy = 1'b1; #1;
        chk("drain_busy_ctl", 32'(ctl), 32'(C_DRNB));
        cyc();
        MEM_busy = 1'b0; EX_redirect = 1'b1; #1;
        chk("drain_ctl", 32'(ctl), 32'(C_DRN));
        cyc(); cyc(); cyc();
        chk("drain_not_halted", 32'(halted), 32'd0);
        cyc();
        chk("halted", 32'(halted), 32'd1);
        chk("halted_ctl", 32'(ctl), 32'(C_HOLD));
        chk("drain_redir_ignored", 32'(flush_cnt), 32'd2);
        cyc();
        chk("halted_stays", 32'(halted), 32'd1);
        RST = 1'b1; #1;
        chk("rst_clears_halted", 32'(halted), 32'd0);
        chk("rst_clears_stall", 32'(stall_cnt), 32'd0);
        chk("rst_run_rules", 32'(ctl), 32'(C_REDIR));
        idle();
        cyc();
        RST = 1'b0;
        cyc();
        chk("post_rst_ctl", 32'(ctl), 32'(C_NORM));

        // Reset in the middle of a drain aborts it
        ID_halt = 1'b1; cyc();
        ID_halt = 1'b0; #1;
        chk("mid_drain_ctl", 32'(ctl), 32'(C_DRN));
        RST = 1'b1; #2; RST = 1'b0;
        cyc();
        chk("abort_drain_ctl", 32'(ctl), 32'(C_NORM));
        for (int i = 0; i < 6; i++) cyc();
        chk("abort_drain_halted", 32'(halted), 32'd0);

        // Reset in the middle of a memory wait aborts it
        MEM_busy = 1'b1; cyc(); #1;
        RST = 1'b1; #1;
        chk("rst_memw_ctl", 32'(ctl), 32'(C_HOLD));
        MEM_busy = 1'b0; #1;
        RST = 1'b0;
        cyc();
        chk("abort_memw_ctl", 32'(ctl), 32'(C_NORM));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
